spi_slave_param: RTL
====================

Name: spi_slave_param

Overview:
Parametrised SPI slave for the system-clock domain. Oversamples SCLK/MOSI/SS on the system clock and handles all four CPOL/CPHA modes and configurable word width. Provides full-duplex transfers: received words go out on a valid strobe, and transmit words come in through a ready/valid holding register. Supports back-to-back words within one SS frame and reports framing and underrun errors.

Parameters:
DATA_W, 8, bits per SPI word (2..32)
CPOL, 0, SCLK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first
SYNC_STAGES, 2, synchroniser flops on SCLK/MOSI/SS (>=2)
FIFO_DEPTH, 4, RX FIFO depth (power of 2); used only with SPI_RX_FIFO_EN

Ports:
i_sys_clk  in  1  system clock; must be >= 8x SCLK frequency
i_rst_n  in  1  asynchronous active-low reset
i_spi_clk  in  1  SPI SCLK (asynchronous)
i_spi_mosi  in  1  SPI MOSI
i_spi_ss  in  1  SPI slave select, active low
o_spi_miso  out  1  SPI MISO; 0 while SS high
i_tx_data  in  DATA_W  next word to transmit
i_tx_valid  in  1  tx word offered
o_tx_ready  out  1  tx holding register empty
o_rx_data  out  DATA_W  received word
o_rx_valid  out  1  received word valid
i_rx_ready  in  1  consumer accepts word (FIFO build only)
o_frame_err  out  1  1-cycle pulse: SS rose mid-word
o_tx_underrun  out  1  1-cycle pulse: word started with empty holding register

Behaviour:
- Reset (i_rst_n low, async): all outputs 0 except o_tx_ready=1. Synchronisers load SCLK=CPOL, SS=1. FSM to IDLE. Bit counter 0. Holding register empty.
- Sync: SCLK/MOSI/SS each pass SYNC_STAGES flops. Edges are detected on the synchronised SCLK against a one-flop delayed copy.
- Leading edge = rising if CPOL=0, else falling. Sample edge = leading if CPHA=0, else trailing. Shift edge = the other edge.
- FSM IDLE: wait for synced SS falling -> LOAD.
- FSM LOAD (1 cycle): copy holding reg into tx shift reg and mark holding empty. If holding was empty, shift reg = 0 and pulse o_tx_underrun. Clear bit counter. -> SHIFT.
- FSM SHIFT: on sample edge, shift MOSI into rx shift reg (MSB_FIRST sets direction) and increment counter.
  - When counter reaches DATA_W, copy the assembled word to o_rx_data, pulse o_rx_valid 1 cycle, wrap counter to 0, and reload tx shift reg as in LOAD. Valid appears exactly 1 sys clk after the synced last sample edge.
- MISO:
  - CPHA=0: first bit is presented from LOAD, so it is stable before the first leading edge. Later bits advance on shift edges.
  - CPHA=1: each bit advances on the leading edge, including the first.
- SS high during SHIFT with counter != 0: discard the partial word, pulse o_frame_err, go to IDLE. SS high with counter == 0: go to IDLE silently.
- SCLK edges while SS high are ignored.
- TX handshake: transfer occurs when i_tx_valid & o_tx_ready on a rising i_sys_clk edge. o_tx_ready drops the next cycle and rises in the cycle after LOAD/reload consumes the word.
  - A load and a consume in the same cycle: the consume takes the old word and the new word is stored, so o_tx_ready stays 0.
- Reset mid-frame: immediate abort with reset values; no error pulse.

Optional Feature:
SPI_RX_FIFO_EN.
- Defined: completed words push into a FIFO_DEPTH-deep RX FIFO. o_rx_data/o_rx_valid show the FIFO head; o_rx_valid is a level held until i_rx_ready.
- Push when full: drop the new word and pulse o_frame_err. Push and pop in the same cycle while full: both succeed.
- Undefined: no FIFO, i_rx_ready ignored, o_rx_valid is a 1-cycle pulse, o_rx_data holds the last word.

Test Plan:
- Mode 0, DATA_W=8, MSB first: send 0x98 then 0xF0 in separate SS frames -> o_rx_data 0x98 then 0xF0, one o_rx_valid pulse each, no errors.
- Full duplex mode 0: preload tx 0xA5 and send 0x3C -> MISO bit sequence 1,0,1,0,0,1,0,1 and o_rx_data=0x3C.
- Full duplex mode 3 (CPOL=1, CPHA=1): preload tx 0xA5 and send 0x3C -> MISO bit sequence 1,0,1,0,0,1,0,1 and o_rx_data=0x3C.
- Back-to-back words in one frame: 0x12, 0x34 with no tx loaded -> two valid pulses, o_tx_underrun at LOAD and at the reload, MISO all 0.
- Frame error: raise SS after 5 bits -> o_frame_err pulses once, no o_rx_valid; the next full frame with 0x55 receives correctly.
- DATA_W=16, MSB_FIRST=0: send 0xBEEF LSB first -> o_rx_data=0xBEEF. Assert i_rst_n low mid-word -> outputs return to reset values immediately.

Source files
------------

// File: rtl/spi_slave_param.sv
// Parametrised SPI slave, oversampled on the system clock; all CPOL/CPHA modes.
// Optional RX FIFO is enabled with `define SPI_RX_FIFO_EN.
module spi_slave_param #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              i_sys_clk,
  input  logic              i_rst_n,
  input  logic              i_spi_clk,
  input  logic              i_spi_mosi,
  input  logic              i_spi_ss,
  output logic              o_spi_miso,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_frame_err,
  output logic              o_tx_underrun,
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic CPOL_B = (CPOL != 0);
  localparam logic CPHA_B = (CPHA != 0);
  localparam logic MSB_B  = (MSB_FIRST != 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  // Handshake: a tx word moves into the holding register on a rising i_sys_clk
  // edge where i_tx_valid and o_tx_ready are both high; o_tx_ready = holding empty.

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_pipe;
  logic [SYNC_STAGES-1:0] mosi_pipe;
  logic [SYNC_STAGES-1:0] ss_pipe;
  logic sclk_s, mosi_s, ss_s;
  logic sclk_d, ss_d;

  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] rx_next;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] load_word;
  logic              hold_full;
  logic              miso_q;
  logic              ss_err_q;
  logic              underrun_q;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic sample_edge, shift_edge, ss_fall;
  logic word_done, consume;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sclk_pipe <= {SYNC_STAGES{CPOL_B}};
      mosi_pipe <= '0;
      ss_pipe   <= {SYNC_STAGES{1'b1}};
      sclk_d    <= CPOL_B;
      ss_d      <= 1'b1;
    end else begin
      sclk_pipe <= {sclk_pipe[SYNC_STAGES-2:0], i_spi_clk};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], i_spi_mosi};
      ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], i_spi_ss};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  assign sclk_s = sclk_pipe[SYNC_STAGES-1];
  assign mosi_s = mosi_pipe[SYNC_STAGES-1];
  assign ss_s   = ss_pipe[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_d;
  assign sclk_fall   = ~sclk_s & sclk_d;
  assign lead_edge   = CPOL_B ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL_B ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA_B ? trail_edge : lead_edge;
  assign shift_edge  = CPHA_B ? lead_edge : trail_edge;
  assign ss_fall     = ss_d & ~ss_s;

  assign rx_next = MSB_B ? {rx_sr[DATA_W-2:0], mosi_s} : {mosi_s, rx_sr[DATA_W-1:1]};

  assign load_word = hold_full ? hold_data : '0;
  assign word_done = (state == ST_SHIFT) & ~ss_s & sample_edge & (bit_cnt == LAST_BIT);
  assign consume   = (state == ST_LOAD) | word_done;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_B ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_B ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_data <= '0;
      hold_full <= 1'b0;
    end else if (i_tx_valid && !hold_full) begin
      // A same-cycle consume saw the old (empty) register, so the new word stays.
      hold_data <= i_tx_data;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      miso_q     <= 1'b0;
      ss_err_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      ss_err_q   <= 1'b0;
      underrun_q <= consume & ~hold_full;
      case (state)
        ST_IDLE: begin
          miso_q  <= 1'b0;
          bit_cnt <= '0;
          if (ss_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          bit_cnt <= '0;
          rx_sr   <= '0;
          // CPHA=0 must present bit 0 before the first leading edge.
          if (!CPHA_B) begin
            miso_q <= first_bit(load_word);
            tx_sr  <= advance(load_word);
          end else begin
            tx_sr  <= load_word;
          end
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (ss_s) begin
            if (bit_cnt != '0) ss_err_q <= 1'b1;
            miso_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            if (sample_edge) begin
              rx_sr <= rx_next;
              if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (!CPHA_B) begin
                  miso_q <= first_bit(load_word);
                  tx_sr  <= advance(load_word);
                end else begin
                  tx_sr  <= load_word;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            // With CPHA=0 the trailing edge right after a wrap must not skip the reloaded bit 0.
            if (shift_edge && (CPHA_B || bit_cnt != '0)) begin
              miso_q <= first_bit(tx_sr);
              tx_sr  <= advance(tx_sr);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_spi_miso    = miso_q;
  assign o_tx_ready    = ~hold_full;
  assign o_tx_underrun = underrun_q;
  assign o_dbg_state   = state;

`ifdef SPI_RX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, pop, push_ok, overflow, ovf_q;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = ~fifo_empty & i_rx_ready;
  assign push_ok    = word_done & (~fifo_full | pop);
  assign overflow   = word_done & fifo_full & ~pop;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ovf_q <= overflow;
      if (push_ok) begin
        fifo_mem[wr_ptr[PTR_W-1:0]] <= rx_next;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign o_rx_data   = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign o_rx_valid  = ~fifo_empty;
  assign o_frame_err = ss_err_q | ovf_q;
`else
  logic [DATA_W-1:0] rx_word_q;
  logic              rx_valid_q;
  logic              unused_rx_ready;
  localparam int     unused_fifo_depth = FIFO_DEPTH;

  assign unused_rx_ready = i_rx_ready;

  always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_word_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= word_done;
      if (word_done) rx_word_q <= rx_next;
    end
  end

  assign o_rx_data   = rx_word_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = ss_err_q;
`endif

endmodule
